// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

endpackage

// File: rtl/signed_divider_ctrl.sv
// Divider control: IDLE/CALC/DONE sequencing plus the quotient-bit counter.
import div_pkg::*;

module signed_divider_ctrl #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk,
    input  logic n_rst,
    input  logic src_valid,
    input  logic special,
    input  logic dest_ready,
    output logic load,
    output logic step,
    output logic finish,
    output logic src_ready,
    output logic dest_valid
);

    localparam int CW = $clog2(WIDTH);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and counter registers; reset discards any in-flight division.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    // Zero divisor and MIN/-1 are resolved on the accept edge.
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (dest_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so they come straight off flops.
    assign src_ready  = (state_q == IDLE);
    assign dest_valid = (state_q == DONE);

endmodule

// File: rtl/signed_divider.sv
// Sequential two's-complement divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, sign fix-up on the final step.
import div_pkg::*;

module signed_divider #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             dest_valid,
    input  logic             dest_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic load, step, finish;

    // Magnitudes are taken at WIDTH+1 bits so that |MIN| is representable.
    logic [WIDTH:0] dvd_ext, dsr_ext, dvd_abs, dsr_abs;
    logic           div0, ovf, special;

    assign dvd_ext = {dividend[WIDTH-1], dividend};
    assign dsr_ext = {divisor[WIDTH-1], divisor};
    assign dvd_abs = dvd_ext[WIDTH] ? -dvd_ext : dvd_ext;
    assign dsr_abs = dsr_ext[WIDTH] ? -dsr_ext : dsr_ext;
    assign div0    = (divisor == '0);
    assign ovf     = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    assign special = div0 | ovf;

    signed_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk        (clk),
        .n_rst      (n_rst),
        .src_valid  (src_valid),
        .special    (special),
        .dest_ready (dest_ready),
        .load       (load),
        .step       (step),
        .finish     (finish),
        .src_ready  (src_ready),
        .dest_valid (dest_valid)
    );

    logic [WIDTH:0]   rem_q, rem_d, dsr_q, shifted;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH+1:0] trial;
    logic             qbit, neg_quot_q, neg_rem_q;
    logic [WIDTH-1:0] quot_q, rmd_q;
    logic             dbz_q;

    // One restoring step: shift {rem,dvd} left, keep the subtraction if it did not borrow.
    // Quotient bits shift into the vacated low end of the dividend register.
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, dsr_q};
        qbit    = ~trial[WIDTH+1];
        rem_d   = qbit ? trial[WIDTH:0] : shifted;
        dvd_d   = {dvd_q[WIDTH-2:0], qbit};
    end

    // Working datapath: capture magnitudes and signs on accept, iterate during CALC.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (load) begin
            rem_q      <= '0;
            dvd_q      <= dvd_abs[WIDTH-1:0];
            dsr_q      <= dsr_abs;
            neg_quot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q  <= dividend[WIDTH-1];
        end else if (step) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
        end
    end

    // Result registers: special cases land on accept, normal results on the last step.
    // Remainder magnitude is below |divisor| <= 2^(WIDTH-1), so WIDTH bits suffice.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            quot_q <= '0;
            rmd_q  <= '0;
            dbz_q  <= 1'b0;
        end else if (load) begin
            dbz_q <= div0;
            if (div0) begin
                quot_q <= '1;
                rmd_q  <= dividend;
            end else if (ovf) begin
                quot_q <= {1'b1, {(WIDTH-1){1'b0}}};
                rmd_q  <= '0;
            end
        end else if (finish) begin
            quot_q <= neg_quot_q ? -dvd_d : dvd_d;
            rmd_q  <= neg_rem_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential two's-complement signed divider: the inverse operation to the combinational signed multiplier in the same arithmetic library. It accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per clock with a shift-subtract (restoring) datapath on operand magnitudes. It returns quotient and remainder over a second valid/ready handshake. It sits beside `signed_multiplier` as the divide half of the datapath's multiply/divide unit.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width; must be ≥ 4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `src_valid`  in  1  operand pair is valid.
- `src_ready`  out  1  divider can accept operands; high only in IDLE.
- `dividend`  in  WIDTH  signed dividend; sampled on the accept edge.
- `divisor`  in  WIDTH  signed divisor; sampled on the accept edge.
- `dest_valid`  out  1  result valid; high only in DONE.
- `dest_ready`  in  1  consumer takes the result.
- `quotient`  out  WIDTH  signed quotient, truncated toward zero.
- `remainder`  out  WIDTH  signed remainder; its sign follows the dividend.
- `div_by_zero`  out  1  the current result came from a zero divisor.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `src_ready`=1.
  - On `src_valid`&&`src_ready`, register the operand signs and magnitudes (|x| computed at WIDTH+1 bits so that −2^(WIDTH−1) is representable).
  - Clear the partial remainder and set the bit counter to 0.
- Accept with special cases, IDLE→DONE directly:
  - divisor==0: quotient = all ones (−1), remainder = dividend, `div_by_zero`=1.
  - dividend==−2^(WIDTH−1) and divisor==−1: quotient = −2^(WIDTH−1), remainder = 0.
- Accept otherwise: IDLE→CALC.
- CALC, each cycle:
  - Shift {rem, dvd} left by 1.
  - trial = rem − |divisor| at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and quotient bit = 1; else quotient bit = 0.
  - Counter increments 0..WIDTH−1.
- CALC exit: on the step with counter==WIDTH−1, go to DONE.
  - Apply sign correction in the same step.
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
- DONE:
  - `quotient`, `remainder` and `div_by_zero` are held stable.
  - On `dest_ready`, go to IDLE.
  - `dest_ready` low: hold indefinitely with no change.
- `src_valid` outside IDLE is ignored; no operand is captured.
- No pass-through: a new operand cannot be accepted on the same edge a result is consumed.
- Reset, at any time including mid-CALC:
  - State becomes IDLE and the in-flight operation is discarded.
  - `src_ready`=1, `dest_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - `src_ready`=1 becomes visible as soon as `n_rst` is low.

## Timing
- Normal operation: the accept edge is edge 0; `dest_valid` rises after edge WIDTH (16 cycles for the default).
- Special cases: `dest_valid` rises after the accept edge itself (1 cycle).
- Result consumed on edge k: `src_ready` is high after edge k; the earliest next accept is edge k+1.
- Throughput: one division per WIDTH+2 cycles when `dest_ready` is held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `div_pkg`:
  - `div_state_e` enum {IDLE, CALC, DONE}.
  - Counter-width localparam `$clog2(WIDTH)`.
  - Default `WIDTH` constant.
- One sub-module, `signed_divider_ctrl`: the FSM plus bit counter.
  - Outputs: `load`, `step`, `finish`, `src_ready`, `dest_valid`.
  - The top level holds the magnitude/remainder datapath and sign fix-up.

## Test plan
- 100 / 7 → `dest_valid` exactly 16 cycles after accept; quotient=14, remainder=2, `div_by_zero`=0.
- Sign mix:
  - −100 / 7 → quotient=−14, remainder=−2.
  - 100 / −7 → quotient=−14, remainder=2.
  - −100 / −7 → quotient=14, remainder=−2.
- Special cases, each with `dest_valid` 1 cycle after accept:
  - 5 / 0 → quotient=16'hFFFF, remainder=5, `div_by_zero`=1.
  - −32768 / −1 → quotient=16'h8000, remainder=0.
- Backpressure:
  - 1000 / 3 with `dest_ready` low for 5 cycles → outputs held at 333/1, `src_ready` stays 0.
  - A `src_valid` pulse during CALC/DONE is ignored.
- Reset mid-operation: `n_rst` low at CALC step 8 → immediately `src_ready`=1, `dest_valid`=0, outputs 0; the next 7 / 2 yields 3/1.
- Random: 10k random signed pairs against the reference model (quotient truncated toward zero), with random `src_valid`/`dest_ready` gaps.
